// File: rtl/s_axi4l_reg_bank_pkg.sv
// s_axi4l_reg_bank_pkg: register indices, response codes and reset values for s_axi4l_reg_bank.
package s_axi4l_reg_bank_pkg;
    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_IRQ_EN   = 1;
    localparam int unsigned REG_IRQ_STAT = 2;
    localparam int unsigned REG_STATUS   = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [63:0] CTRL_RST     = '0;
    localparam logic [63:0] IRQ_EN_RST   = '0;
    localparam logic [63:0] IRQ_STAT_RST = '0;
endpackage

// File: rtl/s_axi4l_reg_bank.sv
// s_axi4l_reg_bank: 4-word register bank (CTRL, IRQ_EN, IRQ_STAT W1C, STATUS RO) with a one-deep read response.
// Define REG_BANK_SLVERR_EN to answer misaligned accesses with SLVERR and flag dropped writes on o_wr_err.
module s_axi4l_reg_bank
    import s_axi4l_reg_bank_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 4
) (
    input  logic                      i_axi_clock,
    input  logic                      i_axi_reset,
    input  logic [AXI_ADDR_WIDTH-1:0] i_waddr,
    input  logic [AXI_DATA_WIDTH-1:0] i_wdata,
    input  logic                      i_wvalid,
    input  logic [AXI_ADDR_WIDTH-1:0] i_raddr,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    output logic [AXI_DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]                o_rresp,
    output logic                      o_rdata_valid,
    input  logic                      i_rdata_ready,
    output logic [AXI_DATA_WIDTH-1:0] o_ctrl,
    input  logic [AXI_DATA_WIDTH-1:0] i_status,
    input  logic [AXI_DATA_WIDTH-1:0] i_irq_set,
    output logic                      o_irq,
    output logic                      o_wr_err
);
    localparam int IW = AXI_ADDR_WIDTH - 2;
    typedef logic [AXI_DATA_WIDTH-1:0] word_t;

    word_t      ctrl_q, ctrl_d, irq_en_q, irq_en_d, irq_stat_q, irq_stat_d;
    word_t      rdata_q, rdata_d, rd_word, clr;
    logic [1:0] rresp_q, rresp_d;
    logic       wvalid_q, wvalid_d, wr_block_q, wr_block_d, rvalid_q, rvalid_d;
    logic       irq_q, irq_d, wr_err_q, wr_err_d;
    logic       wr_fire, wr_bad, wr_ok, rd_bad, rd_accept;
    logic [IW-1:0] widx, ridx;

`ifndef REG_BANK_SLVERR_EN
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_waddr[1:0], i_raddr[1:0]};
`endif

    assign o_rready = ~rvalid_q | i_rdata_ready;

    always_comb begin
        widx = i_waddr[AXI_ADDR_WIDTH-1:2];
        ridx = i_raddr[AXI_ADDR_WIDTH-1:2];
        // wr_block_q holds off a write whose i_wvalid was already high across reset
        wr_fire = i_wvalid & ~wvalid_q & ~wr_block_q;
`ifdef REG_BANK_SLVERR_EN
        wr_bad = wr_fire & ((i_waddr[1:0] != 2'b00) | (widx == IW'(REG_STATUS)));
        rd_bad = i_raddr[1:0] != 2'b00;
`else
        wr_bad = 1'b0;
        rd_bad = 1'b0;
`endif
        wr_ok      = wr_fire & ~wr_bad;
        clr        = (wr_ok && widx == IW'(REG_IRQ_STAT)) ? i_wdata : '0;
        ctrl_d     = (wr_ok && widx == IW'(REG_CTRL)) ? i_wdata : ctrl_q;
        irq_en_d   = (wr_ok && widx == IW'(REG_IRQ_EN)) ? i_wdata : irq_en_q;
        irq_stat_d = (irq_stat_q & ~clr) | i_irq_set;
        irq_d      = |(irq_stat_q & irq_en_q);
        wr_err_d   = wr_bad;
        wr_block_d = wr_block_q & i_wvalid;
        wvalid_d   = i_wvalid;
        rd_word    = (ridx == IW'(REG_CTRL))     ? ctrl_q     :
                     (ridx == IW'(REG_IRQ_EN))   ? irq_en_q   :
                     (ridx == IW'(REG_IRQ_STAT)) ? irq_stat_q :
                     (ridx == IW'(REG_STATUS))   ? i_status   : '0;
        rd_accept  = i_rvalid & o_rready;
        rdata_d    = rd_accept ? (rd_bad ? '0 : rd_word) : rdata_q;
        rresp_d    = rd_accept ? (rd_bad ? RESP_SLVERR : RESP_OKAY) : rresp_q;
        rvalid_d   = rd_accept | (rvalid_q & ~i_rdata_ready);
    end

    always_ff @(posedge i_axi_clock) begin
        if (i_axi_reset) begin
            ctrl_q     <= word_t'(CTRL_RST);
            irq_en_q   <= word_t'(IRQ_EN_RST);
            irq_stat_q <= word_t'(IRQ_STAT_RST);
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
            wr_err_q   <= 1'b0;
            wvalid_q   <= 1'b0;
            wr_block_q <= i_wvalid;
        end else begin
            ctrl_q     <= ctrl_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rvalid_q   <= rvalid_d;
            irq_q      <= irq_d;
            wr_err_q   <= wr_err_d;
            wvalid_q   <= wvalid_d;
            wr_block_q <= wr_block_d;
        end
    end

    assign o_ctrl        = ctrl_q;
    assign o_rdata       = rdata_q;
    assign o_rresp       = rresp_q;
    assign o_rdata_valid = rvalid_q;
    assign o_irq         = irq_q;
    assign o_wr_err      = wr_err_q;
endmodule
